// File: rtl/node_package.sv
// ============================================================================
// Module      : node_package
// Description : Shared types and constants for the home node request/response
//               channel. Requests carry {opcode, addr}; responses carry
//               {opcode, addr, data}. ADDR_WIDTH is the number of memory words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package node_package;

  localparam int WORD_WIDTH   = 8;
  localparam int ADDR_WIDTH   = 16;
  localparam int ADDR_FIELD_W = 8;

  localparam logic [1:0] op_read         = 2'd1;
  localparam logic [1:0] op_data_recv    = 2'd2;
  localparam logic [1:0] op_no_data_recv = 2'd3;

  typedef struct packed {
    logic [1:0]              opcode;
    logic [ADDR_FIELD_W-1:0] addr;
  } ReqType;

  typedef struct packed {
    logic [1:0]              opcode;
    logic [ADDR_FIELD_W-1:0] addr;
    logic [WORD_WIDTH-1:0]   data;
  } DataType;

  typedef enum logic {
    StIdle     = 1'b0,
    StAsserted = 1'b1
  } Type_chn_state;

endpackage

`default_nettype wire

// File: rtl/home_node.sv
// ============================================================================
// Module      : home_node
// Description : Home node serving read requests from a small read-only memory.
//               Requests are announced (pre_rx_req), then strobed (v_rx_req),
//               queued in a request FIFO and answered in arrival order. Each
//               response is announced by pre_tx_data for PRE_CYCLES cycles and
//               then presented for one cycle with v_tx_data.
// Ports       : clk         - clock, all state changes on its rising edge
//               reset       - synchronous active-low reset
//               pre_rx_req  - requester announces a request
//               rx_req      - request {opcode, addr}, qualified by v_rx_req
//               v_rx_req    - one-cycle request strobe
//               pre_tx_data - response announcement
//               tx_data     - response {opcode, addr, data}
//               v_tx_data   - one-cycle response strobe
//               busy        - FIFO non-empty or transmitter active
//               drop_cnt    - saturating count of requests lost to overflow
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module home_node
  import node_package::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PRE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pre_rx_req,
  input  ReqType     rx_req,
  input  logic       v_rx_req,
  output logic       pre_tx_data,
  output DataType    tx_data,
  output logic       v_tx_data,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_MIDX_W = $clog2(ADDR_WIDTH);
  // The pre counter only ever holds PRE_CYCLES-1 down to 0.
  localparam int c_PRE_W  = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0]      c_FULL       = c_CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_FIELD_W-1:0] c_ADDR_LIMIT = ADDR_FIELD_W'(ADDR_WIDTH);
  localparam logic [c_PRE_W-1:0]      c_PRE_LOAD   = c_PRE_W'(PRE_CYCLES - 1);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_PRE  = 2'd1,
    TX_SEND = 2'd2
  } tx_state_t;

  Type_chn_state          r_rx_state;
  ReqType                 r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_CNT_W-1:0]     r_count;
  logic [7:0]             r_drop;
  logic [WORD_WIDTH-1:0]  r_mem [ADDR_WIDTH];

  tx_state_t              r_tx_state;
  logic [c_PRE_W-1:0]     r_pre_cnt;
  DataType                r_resp;
  DataType                r_tx_data;
  logic                   r_pre;
  logic                   r_v;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_store;
  logic                   w_drop;
  ReqType                 w_head;
  logic [c_MIDX_W-1:0]    w_mem_idx;
  DataType                w_resp;

  assign w_push    = (r_rx_state == StAsserted) && v_rx_req;
  assign w_pop     = (r_tx_state == TX_IDLE) && (r_count != '0);
  assign w_full    = (r_count == c_FULL);
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_store   = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_mem_idx = w_head.addr[c_MIDX_W-1:0];

  always_comb begin
    w_resp      = '0;
    w_resp.addr = w_head.addr;
    if ((w_head.opcode == op_read) && (w_head.addr < c_ADDR_LIMIT)) begin
      w_resp.opcode = op_data_recv;
      w_resp.data   = r_mem[w_mem_idx];
    end else begin
      w_resp.opcode = op_no_data_recv;
      w_resp.data   = '0;
    end
  end

  // Receive handshake: a strobe only counts after an announcement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_state <= StIdle;
    end else begin
      case (r_rx_state)
        StIdle:     if (pre_rx_req) r_rx_state <= StAsserted;
        StAsserted: if (v_rx_req)   r_rx_state <= StIdle;
        default:    r_rx_state <= StIdle;
      endcase
    end
  end

  // Request FIFO and overflow counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_store) begin
        r_fifo[r_wr_ptr] <= rx_req;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_store && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_store && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Read-only memory: contents are defined solely by the reset load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
        r_mem[i] <= WORD_WIDTH'(i);
      end
    end
  end

  // Transmit sequencer: pop -> announce for PRE_CYCLES -> one-cycle send.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_pre_cnt  <= '0;
      r_resp     <= '0;
      r_tx_data  <= '0;
      r_pre      <= 1'b0;
      r_v        <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_v <= 1'b0;
          if (w_pop) begin
            r_resp     <= w_resp;
            r_pre      <= 1'b1;
            r_pre_cnt  <= c_PRE_LOAD;
            r_tx_state <= TX_PRE;
          end
        end
        TX_PRE: begin
          if (r_pre_cnt == '0) begin
            r_pre      <= 1'b0;
            r_v        <= 1'b1;
            r_tx_data  <= r_resp;
            r_tx_state <= TX_SEND;
          end else begin
            r_pre_cnt <= r_pre_cnt - 1'b1;
          end
        end
        TX_SEND: begin
          r_v        <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
        default: begin
          r_pre      <= 1'b0;
          r_v        <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign pre_tx_data = r_pre;
  assign v_tx_data   = r_v;
  assign tx_data     = r_tx_data;
  assign drop_cnt    = r_drop;
  assign busy        = (r_count != '0) || (r_tx_state != TX_IDLE);

endmodule

`default_nettype wire
